ln_stream_packer: RTL
=====================

Name: ln_stream_packer

Overview:
- Producer-side front end for the row-wise layer normalisation engine.
- Accepts a tensor as a serial element stream with valid/ready handshake, in row-major order.
- Packs the elements into the flattened SEQ_LEN x EMB_DIM input bus, issues a one-cycle start pulse and holds the bus stable until the engine reports done.
- Then reopens the stream for the next tensor.

Parameters:
- DATA_WIDTH, 16, bits per element (signed fixed point).
- SEQ_LEN, 8, rows per tensor.
- EMB_DIM, 8, elements per row.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  upstream element valid.
- s_ready  out  1  packer can accept an element.
- s_data  in  DATA_WIDTH  element value.
- s_last  in  1  marks final element of a tensor; used only with LN_PACK_LAST_CHECK_EN.
- x_in  out  DATA_WIDTH*SEQ_LEN*EMB_DIM  packed tensor to the engine.
- start  out  1  one-cycle pulse to the engine.
- done  in  1  engine completion pulse.
- busy  out  1  tensor handed off, waiting for done.
- err_last  out  1  sticky framing error flag.

Behaviour:
- Reset (async, rst_n low), values effective immediately:
  - state = S_FILL.
  - row/col counters = 0.
  - x_in = 0, start = 0, busy = 0, err_last = 0.
  - s_ready = 1 once out of reset.
- Counters:
  - row_cnt is $clog2(SEQ_LEN) bits; col_cnt is $clog2(EMB_DIM) bits, minimum 1 bit each.
  - col wraps at EMB_DIM-1 and then row increments.
- Packing: the element accepted at (r,c) is written to x_in[(r*EMB_DIM+c)*DATA_WIDTH +: DATA_WIDTH]. Unwritten slots keep their previous contents.
- Handshake:
  - A transfer occurs on a rising edge where s_valid && s_ready.
  - s_ready is combinational: 1 only in S_FILL.
  - s_data is not sampled without a transfer.
- S_FILL:
  - On each transfer, store the element and advance the counters.
  - On the transfer at (SEQ_LEN-1, EMB_DIM-1), go to S_START and reset the counters to 0.
- S_START:
  - start = 1 for exactly this one cycle; x_in is already complete and stable.
  - Next state is S_WAIT.
- S_WAIT:
  - busy = 1; x_in is held constant; s_ready = 0.
  - On done = 1, go to S_FILL; busy drops the following cycle.
  - done arriving in S_FILL or S_START is ignored.
- Latency:
  - start asserts the cycle after the final transfer.
  - The first new transfer is possible the cycle after done is sampled.
- x_in content is not cleared between tensors. Each new tensor overwrites all slots before the next start.
- Reset mid-operation (any state): return to the reset values above. A partial tensor is discarded and start is never issued for it.
- done and s_valid are in different states, so they are never simultaneous in effect.
- Minimum throughput: SEQ_LEN*EMB_DIM + 2 cycles plus engine time per tensor.

Optional Feature:
- Macro: LN_PACK_LAST_CHECK_EN.
- With the macro, s_last is checked on every transfer in S_FILL:
  - s_last = 1 before the final position: the partial tensor is dropped, counters return to 0, err_last is set, state stays S_FILL.
  - s_last = 0 on the final position: the tensor is still handed off normally and err_last is set.
  - err_last is sticky until reset.
- Without the macro: s_last is ignored and err_last is tied to 0.

Test Plan:
- Reset then stream 64 elements with values 0..63, s_valid held high -> s_ready high for 64 cycles; start pulses once, one cycle after the 64th transfer. x_in slot k equals k; busy = 1.
- In S_WAIT, drive s_valid high with data 0xFFFF for 10 cycles, then pulse done -> s_ready stays 0, x_in unchanged. busy falls one cycle after done; s_ready rises that cycle.
- Random s_valid gaps (about 50% duty), values -32768, 32767, -1, 1 alternating -> every slot correct; exactly one start pulse.
- Assert rst_n low after 20 transfers, release, then stream a full tensor of 0x1234 -> no start before the 64th new transfer; all slots equal 0x1234.
- LN_PACK_LAST_CHECK_EN: s_last on the 10th element, then 64 elements with s_last only on the last -> err_last = 1. Exactly one start; x_in holds the second tensor.
- LN_PACK_LAST_CHECK_EN: 64 elements with no s_last -> start still pulses and err_last = 1. Without the macro, the same stimulus leaves err_last = 0.

Source files
------------

// File: rtl/ln_stream_packer.sv
// ln_stream_packer: collects a row-major element stream into the flattened
// SEQ_LEN x EMB_DIM tensor bus of the layer-norm engine, pulses start once the
// tensor is complete and holds the bus until the engine reports done.
// Optional framing check on s_last: define LN_PACK_LAST_CHECK_EN.
module ln_stream_packer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned SEQ_LEN    = 8,
    parameter int unsigned EMB_DIM    = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic [DATA_WIDTH-1:0]                 s_data,
    input  logic                                  s_last,
    output logic [DATA_WIDTH*SEQ_LEN*EMB_DIM-1:0] x_in,
    output logic                                  start,
    input  logic                                  done,
    output logic                                  busy,
    output logic                                  err_last
);

    localparam int unsigned RowW     = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int unsigned ColW     = (EMB_DIM > 1) ? $clog2(EMB_DIM) : 1;
    localparam int unsigned NumSlots = SEQ_LEN * EMB_DIM;
    localparam int unsigned SlotW    = (NumSlots > 1) ? $clog2(NumSlots) : 1;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                                r_state;
    state_t                                w_state_next;
    logic [RowW-1:0]                       r_row;
    logic [ColW-1:0]                       r_col;
    logic [DATA_WIDTH*NumSlots-1:0]        r_x_in;
    logic                                  w_xfer;
    logic                                  w_col_last;
    logic                                  w_final;
    logic                                  w_early_last;
    logic [SlotW-1:0]                      w_slot;

    assign s_ready    = (r_state == S_FILL);
    assign start      = (r_state == S_START);
    assign busy       = (r_state == S_WAIT);
    assign x_in       = r_x_in;

    assign w_xfer     = s_valid && s_ready;
    assign w_col_last = (r_col == ColW'(EMB_DIM - 1));
    assign w_final    = w_col_last && (r_row == RowW'(SEQ_LEN - 1));
    assign w_slot     = SlotW'(r_row) * SlotW'(EMB_DIM) + SlotW'(r_col);

`ifdef LN_PACK_LAST_CHECK_EN
    logic r_err_last;

    // s_last ahead of the final slot aborts the partial tensor
    assign w_early_last = w_xfer && s_last && !w_final;
    assign err_last     = r_err_last;

    // Sticky framing error: s_last early, or missing on the final element
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_last <= 1'b0;
        end else if (w_xfer && (s_last != w_final)) begin
            r_err_last <= 1'b1;
        end
    end
`else
    logic w_unused_last;

    assign w_unused_last = s_last;
    assign w_early_last  = 1'b0;
    assign err_last      = 1'b0;
`endif

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_FILL:  if (w_xfer && w_final) w_state_next = S_START;
            S_START: w_state_next = S_WAIT;
            S_WAIT:  if (done) w_state_next = S_FILL;
            default: w_state_next = S_FILL;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Row/column position of the next element; wraps to 0 on hand-off or abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_xfer) begin
            if (w_final || w_early_last) begin
                r_row <= '0;
                r_col <= '0;
            end else if (w_col_last) begin
                r_col <= '0;
                r_row <= r_row + RowW'(1);
            end else begin
                r_col <= r_col + ColW'(1);
            end
        end
    end

    // Tensor bus: only the addressed slot is written, everything else holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_in <= '0;
        end else if (w_xfer && !w_early_last) begin
            r_x_in[w_slot*DATA_WIDTH +: DATA_WIDTH] <= s_data;
        end
    end

endmodule
